// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the N-channel scanning multiplexer.
//   - state_t : FSM state encoding (manual, auto-scan, hold)
//   - clog2   : ceiling log2, used to size the channel select. Returns at
//               least 1 so a select port is never zero bits wide.
// ----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        S_MAN  = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// ----------------------------------------------------------------------------
// dwell_timer
//   Free-running dwell counter for the scan mode. Counts 0..DWELL-1 while
//   enabled and raises tick for one cycle on the last count, then wraps to 0.
//   The count is frozen while en is low, which is what lets a hold resume
//   from the exact point it stopped.
// Ports
//   clk   in  1  system clock, rising edge
//   rst   in  1  asynchronous, active-high reset (count -> 0)
//   en    in  1  advance the count this cycle
//   clr   in  1  synchronous clear; wins over en
//   tick  out 1  high during the cycle the count sits at DWELL-1 with en high
// ----------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DWELL) + 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // Combinational so the top can switch channel on the same edge that
    // wraps the count; with DWELL=1 this is high on every enabled cycle.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mux_nch_scan.sv
// ----------------------------------------------------------------------------
// mux_nch_scan
//   Registered N-channel, W-bit multiplexer with manual select, round-robin
//   auto-scan (one channel every DWELL clocks) and a hold/freeze input.
//   Feeds the display path from the switch/sensor buses.
// Parameters
//   W      data width per channel
//   N      channel count (2..16)
//   SELW   select width, derived from N (do not override)
//   DWELL  clocks spent on each channel while scanning
// Ports
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous, active-high reset
//   din      in   N*W    packed channels, channel k = din[k*W +: W]
//   sel_in   in   SELW   manual channel select (values >= N are ignored)
//   mode     in   1      0 = manual, 1 = auto-scan
//   hold     in   1      1 = freeze channel and dwell count
//   dout     out  W      registered data of the selected channel
//   sel_out  out  SELW   channel currently driving dout
//   stb      out  1      one-cycle pulse when sel_out changes
// ----------------------------------------------------------------------------
module mux_nch_scan
    import mux_pkg::*;
#(
    parameter int W     = 2,
    parameter int N     = 4,
    parameter int SELW  = clog2(N),
    parameter int DWELL = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  din,
    input  logic [SELW-1:0] sel_in,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    dout,
    output logic [SELW-1:0] sel_out,
    output logic            stb
);

    // Highest legal channel; wrap and range checks compare against this,
    // never against the all-ones select value, so odd N works.
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    state_t          state;
    state_t          state_next;
    logic [SELW-1:0] sel_next;
    logic            tick;
    logic            timer_en;
    logic            timer_clr;

    // The count only advances while actually scanning. Holding it in clear
    // during manual mode gives a fresh dwell on every entry into scan, while
    // a pass through S_HOLD leaves it untouched.
    assign timer_en  = (state == S_SCAN) && mode && !hold;
    assign timer_clr = (state == S_MAN);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (timer_en),
        .clr  (timer_clr),
        .tick (tick)
    );

    // Next-state and next-select. Priority inside scan: mode=0, then hold,
    // then the dwell step.
    always_comb begin
        state_next = state;
        sel_next   = sel_out;
        case (state)
            S_MAN: begin
                if (sel_in <= LAST_CH) begin
                    sel_next = sel_in;
                end
                if (mode) begin
                    state_next = hold ? S_HOLD : S_SCAN;
                end
            end
            S_SCAN: begin
                if (!mode) begin
                    state_next = S_MAN;
                end else if (hold) begin
                    state_next = S_HOLD;
                end else if (tick) begin
                    sel_next = (sel_out == LAST_CH) ? '0 : sel_out + SELW'(1);
                end
            end
            S_HOLD: begin
                if (!mode) begin
                    state_next = S_MAN;
                end else if (!hold) begin
                    state_next = S_SCAN;
                end
            end
            default: begin
                state_next = S_MAN;
            end
        endcase
    end

    // Output register: data is muxed with the next select so dout and
    // sel_out always describe the same channel in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_MAN;
            sel_out <= '0;
            dout    <= '0;
            stb     <= 1'b0;
        end else begin
            state   <= state_next;
            sel_out <= sel_next;
            dout    <= din[sel_next*W +: W];
            stb     <= (sel_next != sel_out);
        end
    end

endmodule

// File: tb/tb_mux_nch_scan.sv
// ----------------------------------------------------------------------------
// tb_mux_nch_scan
//   Three instances share the stimulus: N=4/DWELL=3, N=3/DWELL=3 (odd
//   channel count) and N=4/DWELL=1. A channel-level reference model predicts
//   every output after each clock; directed steps add fixed expectations.
// ----------------------------------------------------------------------------
module tb_mux_nch_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [1:0] sel_in;
    logic       mode;
    logic       hold;

    logic [1:0] dout4, dout3, dout1;
    logic [1:0] sel4, sel3, sel1;
    logic       stb4, stb3, stb1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_nch_scan #(.W(2), .N(4), .DWELL(3)) u4 (
        .clk(clk), .rst(rst), .din(din), .sel_in(sel_in), .mode(mode),
        .hold(hold), .dout(dout4), .sel_out(sel4), .stb(stb4)
    );

    mux_nch_scan #(.W(2), .N(3), .DWELL(3)) u3 (
        .clk(clk), .rst(rst), .din(din[5:0]), .sel_in(sel_in), .mode(mode),
        .hold(hold), .dout(dout3), .sel_out(sel3), .stb(stb3)
    );

    mux_nch_scan #(.W(2), .N(4), .DWELL(1)) u1 (
        .clk(clk), .rst(rst), .din(din), .sel_in(sel_in), .mode(mode),
        .hold(hold), .dout(dout1), .sel_out(sel1), .stb(stb1)
    );

    // Reference model: 0 = manual, 1 = scanning, 2 = frozen.
    int cfg_n [3] = '{4, 3, 4};
    int cfg_d [3] = '{3, 3, 1};
    int m_st  [3];
    int m_cnt [3];
    int m_sel [3];
    int m_dout[3];
    int m_stb [3];

    function automatic int chan(input logic [7:0] d, input int k);
        logic [7:0] s;
        s = (d >> (2 * k)) & 8'h03;
        return int'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_sel[i] = 0; m_dout[i] = 0; m_stb[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int nsel;
            nsel = m_sel[i];
            if (m_st[i] == 0) begin
                if (int'(sel_in) < cfg_n[i]) nsel = int'(sel_in);
                m_cnt[i] = 0;
                if (mode) m_st[i] = hold ? 2 : 1;
            end else if (m_st[i] == 1) begin
                if (!mode) m_st[i] = 0;
                else if (hold) m_st[i] = 2;
                else if (m_cnt[i] == cfg_d[i] - 1) begin
                    m_cnt[i] = 0;
                    nsel = (m_sel[i] + 1) % cfg_n[i];
                end else m_cnt[i] = m_cnt[i] + 1;
            end else begin
                if (!mode) m_st[i] = 0;
                else if (!hold) m_st[i] = 1;
            end
            m_stb[i]  = (nsel != m_sel[i]) ? 1 : 0;
            m_sel[i]  = nsel;
            m_dout[i] = chan(din, nsel);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " n4.dout"}, 32'(dout4), 32'(m_dout[0]));
        chk({tag, " n4.sel"},  32'(sel4),  32'(m_sel[0]));
        chk({tag, " n4.stb"},  32'(stb4),  32'(m_stb[0]));
        chk({tag, " n3.dout"}, 32'(dout3), 32'(m_dout[1]));
        chk({tag, " n3.sel"},  32'(sel3),  32'(m_sel[1]));
        chk({tag, " n3.stb"},  32'(stb3),  32'(m_stb[1]));
        chk({tag, " d1.dout"}, 32'(dout1), 32'(m_dout[2]));
        chk({tag, " d1.sel"},  32'(sel1),  32'(m_sel[2]));
        chk({tag, " d1.stb"},  32'(stb1),  32'(m_stb[2]));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_all(tag);
    endtask

    int scan_seq[12] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1, 1, 1};

    initial begin
        rst = 1'b1; din = 8'h00; sel_in = 2'd0; mode = 1'b0; hold = 1'b0;
        model_reset();
        step("reset");
        step("reset");
        chk("reset n4.sel", 32'(sel4), 32'd0);
        chk("reset n4.stb", 32'(stb4), 32'd0);

        // release, stay in manual on channel 0
        rst = 1'b0;
        step("rel");
        chk("rel n4.stb", 32'(stb4), 32'd0);

        // manual select 0 -> 3
        din = 8'b11_10_01_00; sel_in = 2'd3;
        step("man");
        chk("man n4.dout", 32'(dout4), 32'd3);
        chk("man n4.sel",  32'(sel4),  32'd3);
        chk("man n4.stb",  32'(stb4),  32'd1);
        chk("man n3.sel out-of-range", 32'(sel3), 32'd0);
        chk("man n3.stb out-of-range", 32'(stb3), 32'd0);
        step("man hold");
        chk("man held n4.stb", 32'(stb4), 32'd0);
        din = 8'b01_00_11_10;
        step("man track");
        chk("man track n4.dout", 32'(dout4), 32'd1);

        // scan from channel 2, wrap 3 -> 0
        sel_in = 2'd2;
        step("pre-scan");
        mode = 1'b1;
        for (int s = 0; s < 12; s++) begin
            step("scan");
            chk("scan n4.seq", 32'(sel4), 32'(scan_seq[s]));
            chk("scan n4.stb", 32'(stb4), (s == 3 || s == 6 || s == 9) ? 32'd1 : 32'd0);
            if (s >= 1) chk("scan d1.stb", 32'(stb1), 32'd1);
            if (s == 3) chk("scan n3.wrap", 32'(sel3), 32'd0);
        end
        step("scan13");
        chk("scan13 n4.sel", 32'(sel4), 32'd2);
        step("scan14");

        // freeze one clock into the dwell, then resume
        hold = 1'b1;
        for (int s = 0; s < 10; s++) begin
            step("hold");
            chk("hold n4.sel", 32'(sel4), 32'd2);
            chk("hold n4.stb", 32'(stb4), 32'd0);
        end
        hold = 1'b0;
        step("resume");
        step("resume");
        chk("resume n4.sel", 32'(sel4), 32'd2);
        step("resume");
        chk("resume adv n4.sel", 32'(sel4), 32'd3);
        chk("resume adv n4.stb", 32'(stb4), 32'd1);

        // mode=0 wins over hold while frozen
        hold = 1'b1;
        step("prio");
        mode = 1'b0; sel_in = 2'd0;
        step("prio");
        chk("prio n4.sel kept", 32'(sel4), 32'd3);
        step("prio");
        chk("prio n4.sel", 32'(sel4), 32'd0);
        chk("prio n4.stb", 32'(stb4), 32'd1);

        // asynchronous reset in the middle of a scan on channel 2
        hold = 1'b0; sel_in = 2'd2;
        step("pre-rst");
        mode = 1'b1;
        step("pre-rst");
        step("pre-rst");
        chk("pre-rst n4.sel", 32'(sel4), 32'd2);
        rst = 1'b1;
        #1;
        chk("async n4.dout", 32'(dout4), 32'd0);
        chk("async n4.sel",  32'(sel4),  32'd0);
        chk("async n4.stb",  32'(stb4),  32'd0);
        model_reset();
        check_all("async");
        step("rst held");
        mode = 1'b0; sel_in = 2'd0; rst = 1'b0;
        step("post-rst");
        chk("post-rst n4.stb", 32'(stb4), 32'd0);
        step("post-rst");

        // randomized traffic against the model
        for (int s = 0; s < 400; s++) begin
            din    = 8'($urandom);
            sel_in = 2'($urandom_range(0, 3));
            mode   = ($urandom_range(0, 9) != 0);
            hold   = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
